// File: rtl/crc_serial_engine.sv
// rtl/crc_serial_engine.sv - serial CRC engine: pass-through, then append or check with one of two polynomials
module crc_serial_engine #(
    parameter int             W_A    = 5,
    parameter logic [W_A-1:0] POLY_A = 5'b00101,
    parameter logic [W_A-1:0] RES_A  = 5'b01100,
    parameter int             W_B    = 16,
    parameter logic [W_B-1:0] POLY_B = 16'h8005,
    parameter logic [W_B-1:0] RES_B  = 16'h800D
) (
    input  logic clk,
    input  logic rst_L,
    input  logic clear,
    input  logic start,
    input  logic sel,
    input  logic mode,
    input  logic inb,
    input  logic recving,
    input  logic pause_out,
    output logic pause_in,
    output logic outb,
    output logic sending,
    output logic done,
    output logic crc_ok,
    output logic crc_err
);
    localparam int CW = $clog2(W_B + 1);
    localparam logic [W_B-1:0] MASK_A  = ~({W_B{1'b1}} << W_A);
    localparam logic [W_B-1:0] POLY_AX = W_B'(POLY_A);
    localparam logic [W_B-1:0] RES_AX  = W_B'(RES_A);

    typedef enum logic [1:0] {IDLE, CALC, APPEND, CHECK} state_t;

    state_t         state;
    logic [W_B-1:0] crc;
    logic [CW-1:0]  cnt;
    logic           sel_q;
    logic           mode_q;

    logic [W_B-1:0] mask;
    logic [W_B-1:0] poly;
    logic [W_B-1:0] res;
    logic [W_B-1:0] top;
    logic [W_B-1:0] crc_nxt;
    logic [CW-1:0]  wlast;
    logic           fb;
    logic           app_bit;
    logic           last_bit;

    // The one-hot "top" marks the active MSB, so bit picks are reductions rather than variable indexing.
    always_comb begin
        mask     = sel_q ? {W_B{1'b1}} : MASK_A;
        poly     = sel_q ? POLY_B : POLY_AX;
        res      = sel_q ? RES_B : RES_AX;
        wlast    = sel_q ? CW'(W_B - 1) : CW'(W_A - 1);
        top      = mask & ~(mask >> 1);
        fb       = inb ^ (|(crc & top));
        crc_nxt  = ((crc << 1) ^ (fb ? poly : '0)) & mask;
        app_bit  = ~(|(crc & (top >> cnt)));
        last_bit = (state == APPEND) && !pause_out && (cnt == wlast);
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state   <= IDLE;
            crc     <= '1;
            cnt     <= '0;
            sel_q   <= 1'b0;
            mode_q  <= 1'b0;
            crc_ok  <= 1'b0;
            crc_err <= 1'b0;
        end else if (clear) begin
            state   <= IDLE;
            crc     <= '1;
            cnt     <= '0;
            crc_ok  <= 1'b0;
            crc_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sel_q   <= sel;
                        mode_q  <= mode;
                        crc     <= sel ? {W_B{1'b1}} : MASK_A;
                        crc_ok  <= 1'b0;
                        crc_err <= 1'b0;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    if (recving) begin
                        if (!pause_out) begin
                            crc <= crc_nxt;
                        end
                    end else begin
                        cnt   <= '0;
                        state <= mode_q ? CHECK : APPEND;
                    end
                end
                APPEND: begin
                    if (!pause_out) begin
                        if (cnt == wlast) begin
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                CHECK: begin
                    crc_ok  <= (crc == res);
                    crc_err <= (crc != res);
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign outb     = (state == APPEND) ? app_bit : ((state == CHECK) ? 1'b0 : inb);
    assign sending  = ((state == CALC) && recving) || (state == APPEND);
    assign pause_in = (state == APPEND);
    assign done     = !clear && ((state == CHECK) || last_bit);
endmodule
